// File: rtl/ls_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls_arbiter_pkg
// Description : Shared types for the local-store arbiter: requester tags
//               that mark who owns the read data returning next cycle, the
//               arbiter FSM states, and the address bit that selects the
//               code or data partition.
// Revision    : 1.0 - initial release
// ============================================================================
package ls_arbiter_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LSU  = 2'd1,
        TAG_DMA  = 2'd2,
        TAG_IF   = 2'd3
    } tag_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Big-endian bit 13 of the byte address: 0 = code, 1 = data partition.
    localparam int c_part_bit = 13;

endpackage
`default_nettype wire

// File: rtl/ls_word_select.sv
`default_nettype none
// ============================================================================
// Module      : ls_word_select
// Description : Extracts one 32-bit instruction word from a 128-bit
//               local-store line. Offset 0 is the leftmost (bits 0:31) word.
// Ports       : line - 128-bit line, big-endian numbering
//               off  - word offset within the line (addr bits 28:29)
//               word - selected 32-bit word
// Revision    : 1.0 - initial release
// ============================================================================
module ls_word_select (
    input  logic [0:127] line,
    input  logic [1:0]   off,
    output logic [0:31]  word
);

    always_comb begin
        word = line[0:31];
        case (off)
            2'b00:   word = line[0:31];
            2'b01:   word = line[32:63];
            2'b10:   word = line[64:95];
            2'b11:   word = line[96:127];
            default: word = line[0:31];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ls_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ls_arbiter
// Description : Single-port local-store arbiter for the LSU, the DMA engine
//               and instruction fetch. One access per cycle, read data one
//               cycle after grant, atomic DMA bursts, aging for IF, and
//               write protection of the code partition.
// Ports       : clk/rst                      - clock, async active-high reset
//               lsu_*                        - load/store unit port
//               dma_*                        - DMA burst port
//               if_*                         - instruction fetch port
//               mem_en/we/idx/wdata/rdata    - local-store array interface
//               wr_viol                      - dropped code-partition write
// Revision    : 1.0 - initial release
// ============================================================================
module ls_arbiter
    import ls_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int IDX_LO       = 14,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [0:ADDR_W-1] lsu_addr,
    input  logic [0:127]      lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [0:127]      lsu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [0:ADDR_W-1] dma_addr,
    input  logic [0:3]        dma_len,
    input  logic [0:127]      dma_wdata,
    output logic              dma_gnt,
    output logic              dma_beat,
    output logic              dma_rvalid,
    output logic [0:127]      dma_rdata,
    output logic              dma_done,
    input  logic              if_req,
    input  logic [0:ADDR_W-1] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [0:31]       if_inst,
    output logic              mem_en,
    output logic              mem_we,
    output logic [IDX_LO:27]  mem_idx,
    output logic [0:127]      mem_wdata,
    input  logic [0:127]      mem_rdata,
    output logic              wr_viol
);

    localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);
    localparam logic [3:0]         c_max_len    = 4'(MAX_BURST);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [0:ADDR_W-1]   r_burst_addr;
    logic [3:0]          r_burst_rem;
    logic                r_burst_we;
    logic [c_cnt_w-1:0]  r_starve_cnt;
    tag_t                r_tag;
    tag_t                w_tag_nxt;
    logic [1:0]          r_if_off;

    logic [3:0]          w_len;
    logic                w_starved;
    logic [0:ADDR_W-1]   w_addr;
    logic                w_write;
    logic [0:31]         w_word;
    logic                w_unused_bits;

    // Burst length after clamping: 0 means a single beat.
    always_comb begin
        w_len = dma_len;
        if (dma_len == 4'd0) begin
            w_len = 4'd1;
        end else if (dma_len > c_max_len) begin
            w_len = c_max_len;
        end
    end

    assign w_starved = (r_starve_cnt >= c_starve_max);

    // Grant selection, array drive and next state. Everything is forced low
    // while rst is high so outputs drop at once, not at the next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = TAG_NONE;
        w_addr      = '0;
        w_write     = 1'b0;
        lsu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        dma_beat    = 1'b0;
        dma_done    = 1'b0;
        if_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_wdata   = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (if_req && w_starved) begin
                        if_gnt    = 1'b1;
                        w_addr    = if_addr;
                        w_tag_nxt = TAG_IF;
                    end else if (lsu_req) begin
                        lsu_gnt   = 1'b1;
                        w_addr    = lsu_addr;
                        w_write   = lsu_we;
                        mem_wdata = lsu_wdata;
                        w_tag_nxt = lsu_we ? TAG_NONE : TAG_LSU;
                    end else if (dma_req) begin
                        dma_gnt   = 1'b1;
                        dma_beat  = 1'b1;
                        w_addr    = dma_addr;
                        w_write   = dma_we;
                        mem_wdata = dma_wdata;
                        w_tag_nxt = dma_we ? TAG_NONE : TAG_DMA;
                        if (w_len == 4'd1) begin
                            dma_done = 1'b1;
                        end else begin
                            w_state_nxt = ST_BURST;
                        end
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        w_addr    = if_addr;
                        w_tag_nxt = TAG_IF;
                    end
                end
                ST_BURST: begin
                    dma_beat  = 1'b1;
                    w_addr    = r_burst_addr;
                    w_write   = r_burst_we;
                    mem_wdata = dma_wdata;
                    w_tag_nxt = r_burst_we ? TAG_NONE : TAG_DMA;
                    if (r_burst_rem == 4'd1) begin
                        dma_done    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            mem_en = lsu_gnt | dma_beat | if_gnt;
        end
        // A write aimed at the code partition still takes its slot but the
        // array write strobe is suppressed.
        mem_we  = w_write &  w_addr[c_part_bit];
        wr_viol = w_write & ~w_addr[c_part_bit];
        mem_idx = w_addr[IDX_LO:27];
    end

    assign w_unused_bits = ^{w_addr[0:c_part_bit-1], w_addr[28:ADDR_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_addr <= '0;
            r_burst_rem  <= '0;
            r_burst_we   <= 1'b0;
            r_starve_cnt <= '0;
            r_tag        <= TAG_NONE;
            r_if_off     <= 2'b00;
        end else begin
            r_tag <= w_tag_nxt;
            // The first beat goes out with the grant; the counter holds the
            // beats still to be issued from BURST.
            if (dma_gnt) begin
                r_burst_addr <= dma_addr + ADDR_W'(16);
                r_burst_rem  <= w_len - 4'd1;
                r_burst_we   <= dma_we;
            end else if (dma_beat) begin
                r_burst_addr <= r_burst_addr + ADDR_W'(16);
                r_burst_rem  <= r_burst_rem - 4'd1;
            end
            if (if_gnt) begin
                r_if_off <= if_addr[28:29];
            end
            if (if_req && !if_gnt) begin
                if (r_starve_cnt < c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    ls_word_select u_word_select (
        .line (mem_rdata),
        .off  (r_if_off),
        .word (w_word)
    );

    assign lsu_rvalid = (r_tag == TAG_LSU);
    assign dma_rvalid = (r_tag == TAG_DMA);
    assign if_rvalid  = (r_tag == TAG_IF);
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
    assign if_inst    = if_rvalid  ? w_word    : '0;

endmodule
`default_nettype wire

// File: tb/tb_ls_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls_arbiter
// Description : Testbench for ls_arbiter with a local-store array model,
//               a queue-based reference of the arbitration rules checked on
//               every cycle, and directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         lsu_req, lsu_we;
    logic [0:31]  lsu_addr;
    logic [0:127] lsu_wdata;
    logic         lsu_gnt, lsu_rvalid;
    logic [0:127] lsu_rdata;
    logic         dma_req, dma_we;
    logic [0:31]  dma_addr;
    logic [0:3]   dma_len;
    logic [0:127] dma_wdata;
    logic         dma_gnt, dma_beat, dma_rvalid, dma_done;
    logic [0:127] dma_rdata;
    logic         if_req;
    logic [0:31]  if_addr;
    logic         if_gnt, if_rvalid;
    logic [0:31]  if_inst;
    logic         mem_en, mem_we, wr_viol;
    logic [14:27] mem_idx;
    logic [0:127] mem_wdata;
    logic [0:127] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ls_arbiter dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_inst(if_inst),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_viol(wr_viol)
    );

    function automatic logic [127:0] init_line(input int idx);
        if (idx == 'h200) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
        return {32'(idx), ~32'(idx), 32'(idx) ^ 32'h5A5A5A5A, 32'hC0DE0000 | 32'(idx)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Local-store array: synchronous read, lines default to init_line().
    logic [127:0] mem_arr [int];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_arr.exists(int'(mem_idx)) ? mem_arr[int'(mem_idx)]
                                                       : init_line(int'(mem_idx));
            if (mem_we) mem_arr[int'(mem_idx)] = mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]  m_q[$];
    logic         m_burst_we = 1'b0;
    int           m_starve = 0;
    int           m_owner = 0;
    int           m_off = 0;
    logic [127:0] m_data = '0;
    logic [127:0] ref_mem [int];

    logic         e_lsu_gnt, e_lsu_rv, e_dma_gnt, e_beat, e_dma_rv, e_done;
    logic         e_if_gnt, e_if_rv, e_en, e_we, e_viol, acc, acc_we;
    logic [127:0] e_lsu_rd, e_dma_rd, acc_wd, n_data, tmp;
    logic [31:0]  e_inst, acc_addr;
    int           e_idx, n_owner, n_off, len;

    function automatic logic [127:0] ref_line(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
    endfunction

    always @(negedge clk) begin : p_compare
        {e_lsu_gnt, e_lsu_rv, e_dma_gnt, e_beat, e_dma_rv, e_done} = '0;
        {e_if_gnt, e_if_rv, e_en, e_we, e_viol, acc, acc_we} = '0;
        e_lsu_rd = '0; e_dma_rd = '0; e_inst = '0; acc_wd = '0; acc_addr = '0;
        n_data = '0; e_idx = 0; n_owner = 0; n_off = m_off; len = 0;
        if (!rst) begin
            if (m_owner == 1) begin e_lsu_rv = 1'b1; e_lsu_rd = m_data; end
            if (m_owner == 2) begin e_dma_rv = 1'b1; e_dma_rd = m_data; end
            if (m_owner == 3) begin
                e_if_rv = 1'b1;
                tmp = m_data >> (96 - 32 * m_off);
                e_inst = tmp[31:0];
            end
            if (m_q.size() > 0) begin
                e_beat = 1'b1; acc = 1'b1; acc_addr = m_q[0];
                acc_we = m_burst_we; acc_wd = dma_wdata;
                e_done = (m_q.size() == 1);
                if (!acc_we) n_owner = 2;
            end else if (if_req && m_starve >= 15) begin
                e_if_gnt = 1'b1; acc = 1'b1; acc_addr = if_addr;
                n_owner = 3; n_off = int'((if_addr >> 2) & 32'd3);
            end else if (lsu_req) begin
                e_lsu_gnt = 1'b1; acc = 1'b1; acc_addr = lsu_addr;
                acc_we = lsu_we; acc_wd = lsu_wdata;
                if (!lsu_we) n_owner = 1;
            end else if (dma_req) begin
                len = int'(dma_len);
                if (len == 0) len = 1;
                if (len > 8) len = 8;
                e_dma_gnt = 1'b1; e_beat = 1'b1; acc = 1'b1; acc_addr = dma_addr;
                acc_we = dma_we; acc_wd = dma_wdata;
                e_done = (len == 1);
                if (!dma_we) n_owner = 2;
            end else if (if_req) begin
                e_if_gnt = 1'b1; acc = 1'b1; acc_addr = if_addr;
                n_owner = 3; n_off = int'((if_addr >> 2) & 32'd3);
            end
            if (acc) begin
                e_en  = 1'b1;
                e_idx = int'((acc_addr >> 4) & 32'h3FFF);
                if (acc_we) begin
                    if (((acc_addr >> 18) & 32'd1) != 0) e_we = 1'b1;
                    else e_viol = 1'b1;
                end
                n_data = ref_line(e_idx);
            end
        end
        chk("lsu_gnt", lsu_gnt, e_lsu_gnt);
        chk("lsu_rvalid", lsu_rvalid, e_lsu_rv);
        chk("lsu_rdata", lsu_rdata, e_lsu_rd);
        chk("dma_gnt", dma_gnt, e_dma_gnt);
        chk("dma_beat", dma_beat, e_beat);
        chk("dma_done", dma_done, e_done);
        chk("dma_rvalid", dma_rvalid, e_dma_rv);
        chk("dma_rdata", dma_rdata, e_dma_rd);
        chk("if_gnt", if_gnt, e_if_gnt);
        chk("if_rvalid", if_rvalid, e_if_rv);
        chk("if_inst", if_inst, e_inst);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("wr_viol", wr_viol, e_viol);
        if (e_en) chk("mem_idx", mem_idx, e_idx);
        if (e_we) chk("mem_wdata", mem_wdata, acc_wd);
        if (rst) begin
            m_q.delete(); m_starve = 0; m_owner = 0; m_off = 0;
        end else begin
            if (e_beat && !e_dma_gnt) void'(m_q.pop_front());
            if (e_dma_gnt) begin
                m_burst_we = dma_we;
                for (int k = 1; k < len; k++) m_q.push_back(dma_addr + 32'(16 * k));
            end
            if (e_we) ref_mem[e_idx] = acc_wd;
            m_owner = n_owner; m_data = n_data; m_off = n_off;
            if (if_req && !e_if_gnt) begin
                if (m_starve < 15) m_starve++;
            end else begin
                m_starve = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int first_if, beats, done_at;

    initial begin : p_stim
        rst = 1'b1;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0004_0010; lsu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0004_0000; dma_len = 4'd1; dma_wdata = '0;
        if_req  = 1'b1; if_addr = 32'h0000_2008;
        @(negedge clk);
        chk("rst_lsu_gnt", lsu_gnt, 1'b0);
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_lsu_rvalid", lsu_rvalid, 1'b0);
        cyc(); rst = 1'b0; lsu_req = 1'b0; dma_req = 1'b0; if_req = 1'b0;
        cyc();

        // LSU and IF together: LSU first, IF next cycle.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0004_0010;
        if_req = 1'b1; if_addr = 32'h0004_0024;
        @(negedge clk);
        chk("t1_lsu_gnt", lsu_gnt, 1'b1);
        chk("t1_if_wait", if_gnt, 1'b0);
        cyc(); lsu_req = 1'b0;
        @(negedge clk);
        chk("t1_if_gnt", if_gnt, 1'b1);
        chk("t1_lsu_rvalid", lsu_rvalid, 1'b1);
        chk("t1_lsu_rdata", lsu_rdata, init_line(1));
        cyc(); if_req = 1'b0;
        cyc();

        // Store into code partition is dropped.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h0000_0040;
        lsu_wdata = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
        @(negedge clk);
        chk("t2_lsu_gnt", lsu_gnt, 1'b1);
        chk("t2_mem_we", mem_we, 1'b0);
        chk("t2_wr_viol", wr_viol, 1'b1);
        cyc(); lsu_we = 1'b0;
        @(negedge clk);
        chk("t2_viol_clear", wr_viol, 1'b0);
        cyc(); lsu_req = 1'b0;
        @(negedge clk);
        chk("t2_unchanged", lsu_rdata, init_line(4));
        cyc();

        // DMA read burst of 4 with LSU waiting from the second cycle.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0004_0000; dma_len = 4'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_beat", dma_beat, 1'b1);
            chk("t3_idx", mem_idx, k);
            chk("t3_done", dma_done, (k == 3));
            if (k == 0) chk("t3_gnt", dma_gnt, 1'b1);
            else chk("t3_lsu_wait", lsu_gnt, 1'b0);
            cyc();
            dma_req = 1'b0; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0004_0200;
        end
        @(negedge clk);
        chk("t3_lsu_after", lsu_gnt, 1'b1);
        chk("t3_last_rvalid", dma_rvalid, 1'b1);
        cyc(); lsu_req = 1'b0;
        cyc();

        // IF starvation under continuous LSU traffic.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0004_0300;
        if_req = 1'b1; if_addr = 32'h0004_0400;
        first_if = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (if_gnt && first_if < 0) first_if = i;
            cyc();
        end
        chk("t4_if_first", first_if, 15);
        lsu_req = 1'b0; if_req = 1'b0;
        cyc();

        // Instruction word select.
        if_req = 1'b1; if_addr = 32'h0000_2008;
        @(negedge clk);
        chk("t5_if_gnt", if_gnt, 1'b1);
        cyc(); if_req = 1'b0;
        @(negedge clk);
        chk("t5_if_rvalid", if_rvalid, 1'b1);
        chk("t5_if_inst", if_inst, 32'h8899AABB);
        cyc();

        // len 0 acts as a single beat.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0004_0500; dma_len = 4'd0;
        dma_wdata = 128'h11111111_22222222_33333333_44444444;
        @(negedge clk);
        chk("x_len0_done", dma_done, 1'b1);
        cyc();
        // len 15 clamps to 8 beats, all into the code partition.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0800; dma_len = 4'hF;
        beats = 0; done_at = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (dma_beat) beats++;
            if (dma_done) done_at = i;
            cyc();
            dma_req = 1'b0; dma_wdata = dma_wdata + 128'd1;
        end
        chk("x_clamp_beats", beats, 8);
        chk("x_clamp_done", done_at, 7);

        // Reset during beat 2 of an 8-beat DMA write.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0004_0100; dma_len = 4'd8;
        dma_wdata = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        @(negedge clk);
        chk("t6_gnt", dma_gnt, 1'b1);
        cyc(); dma_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_beat", dma_beat, 1'b0);
        chk("t6_rst_done", dma_done, 1'b0);
        chk("t6_rst_mem_en", mem_en, 1'b0);
        cyc(); cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_beat", dma_beat, 1'b0);
            chk("t6_no_done", dma_done, 1'b0);
            cyc();
        end
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0004_0110;
        @(negedge clk);
        chk("t6_lsu_gnt", lsu_gnt, 1'b1);
        cyc(); lsu_req = 1'b0;
        @(negedge clk);
        chk("t6_beat2_unwritten", lsu_rdata, init_line('h11));
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
